// File: rtl/gen_osc_pkg.sv
// Shared types and constants for the multi-channel oscillator.
package gen_osc_pkg;

    typedef enum logic [1:0] {
        MODE_SAW    = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SILENT = 2'd3
    } osc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } osc_state_e;

    // Frequency-to-step scale: step = (f * K) >> SH, 699/2 ~= 2^24 / 48000
    localparam int unsigned DEF_STEP_K  = 699;
    localparam int unsigned DEF_STEP_SH = 1;

endpackage

// File: rtl/osc_shape.sv
// Combinational waveform mapper: top phase bits, mode and pulse width to sample.
module osc_shape
    import gen_osc_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic [OUT_W-1:0] phase_i,
    input  osc_mode_e        mode_i,
    input  logic [OUT_W-1:0] pw_i,
    output logic [OUT_W-1:0] sample_o
);

    logic [OUT_W-1:0] dbl;

    assign dbl = {phase_i[OUT_W-2:0], 1'b0};

    // Select the waveform for the current channel
    always_comb begin
        sample_o = '0;
        case (mode_i)
            MODE_SAW:    sample_o = phase_i;
            MODE_SQUARE: sample_o = (phase_i < pw_i) ? '1 : '0;
            MODE_TRI:    sample_o = phase_i[OUT_W-1] ? ~dbl : dbl;
            default:     sample_o = '0;
        endcase
    end

endmodule

// File: rtl/gen_osc_multi.sv
// Time-multiplexed multi-channel oscillator: one shared phase adder and one
// shaper serve all channels, one channel per cycle after each sample tick.
module gen_osc_multi
    import gen_osc_pkg::*;
#(
    parameter int          NUM_CH  = 4,
    parameter int          ACC_W   = 24,
    parameter int          OUT_W   = 16,
    parameter int          DIV     = 1000,
    parameter int unsigned STEP_K  = DEF_STEP_K,
    parameter int unsigned STEP_SH = DEF_STEP_SH
) (
    input  logic                    i_clk48,
    input  logic                    i_rst48_n,
    input  logic [NUM_CH-1:0]       i_pause,
    input  logic [NUM_CH-1:0]       i_sync,
    input  logic [2*NUM_CH-1:0]     i_mode,
    input  logic [24*NUM_CH-1:0]    i_targetf,
    input  logic [OUT_W*NUM_CH-1:0] i_pw,
    output logic [OUT_W*NUM_CH-1:0] o_sample,
    output logic                    o_pulse,
    output logic                    o_busy
);

    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIV_W  = $clog2(DIV);
    localparam int PROD_W = 24 + 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0]        div_q;
    logic                    tick;
    osc_state_e              state_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    pulse_q;
    logic                    busy_q;
    logic [ACC_W-1:0]        phase_q  [NUM_CH];
    logic [OUT_W-1:0]        shadow_q [NUM_CH];
    logic [OUT_W*NUM_CH-1:0] sample_q;

    logic                    sel_pause;
    logic                    sel_sync;
    osc_mode_e               sel_mode;
    logic [23:0]             sel_f;
    logic [OUT_W-1:0]        sel_pw;
    logic [ACC_W-1:0]        sel_phase;
    logic [PROD_W-1:0]       prod;
    logic [ACC_W-1:0]        step;
    logic [ACC_W-1:0]        sum;
    logic [ACC_W-1:0]        phase_d;
    logic [OUT_W-1:0]        shape_out;
    logic                    active;

    assign tick   = (div_q == DIV_LAST);
    assign active = (state_q == ST_RUN);

    // Sample-rate divider, free running 0..DIV-1
    always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
        if (!i_rst48_n) begin
            div_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
        end
    end

    // Pick the inputs and stored phase of the channel being processed
    always_comb begin
        sel_pause = 1'b0;
        sel_sync  = 1'b0;
        sel_mode  = MODE_SAW;
        sel_f     = '0;
        sel_pw    = '0;
        sel_phase = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_pause = i_pause[i];
                sel_sync  = i_sync[i];
                sel_mode  = osc_mode_e'(i_mode[2*i +: 2]);
                sel_f     = i_targetf[24*i +: 24];
                sel_pw    = i_pw[OUT_W*i +: OUT_W];
                sel_phase = phase_q[i];
            end
        end
    end

    // Step at full product width, then the single shared phase adder
    always_comb begin
        prod = PROD_W'(sel_f) * PROD_W'(STEP_K);
        step = ACC_W'(prod >> STEP_SH);
        sum  = sel_phase + step;
        if (sel_sync) begin
            phase_d = '0;
        end else if (sel_pause || (sel_mode == MODE_SILENT)) begin
            phase_d = sel_phase;
        end else begin
            phase_d = sum;
        end
    end

    osc_shape #(
        .OUT_W (OUT_W)
    ) u_shape (
        .phase_i  (phase_d[ACC_W-1 -: OUT_W]),
        .mode_i   (sel_mode),
        .pw_i     (sel_pw),
        .sample_o (shape_out)
    );

    // Store updated phase and shaped sample for the active channel
    always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
        if (!i_rst48_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                phase_q[i]  <= '0;
                shadow_q[i] <= '0;
            end
        end else if (active) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    phase_q[i]  <= phase_d;
                    shadow_q[i] <= shape_out;
                end
            end
        end
    end

    // Publish all shadows at once; the last channel is forwarded so the new
    // set is already visible during the COMMIT cycle alongside o_pulse
    always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
        if (!i_rst48_n) begin
            sample_q <= '0;
        end else if (active && (idx_q == LAST_IDX)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sample_q[OUT_W*i +: OUT_W] <= (i == NUM_CH - 1) ? shape_out : shadow_q[i];
            end
        end
    end

    // Sequencer: IDLE -> RUN (one cycle per channel) -> COMMIT -> IDLE
    always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
        if (!i_rst48_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_q <= ST_RUN;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_COMMIT;
                        pulse_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sample = sample_q;
    assign o_pulse  = pulse_q;
    assign o_busy   = busy_q;

endmodule
